// File: rtl/snake_pkg.sv
// Shared snake-game definitions: direction codes, body FSM states and default
// playfield/body dimensions used by the body controller, item generator and renderer.
package snake_pkg;

  localparam int XSIZE_DEF    = 48;
  localparam int YSIZE_DEF    = 64;
  localparam int MAX_SIZE_DEF = 100;
  localparam int COORD_W      = 6;
  localparam int SIZE_W       = 12;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SHIFT = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  // Opposite directions differ only in the low bit of the encoding.
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_hit_detect.sv
// Combinational check of one cell against the first len segments of a packed body.
module snake_hit_detect
  import snake_pkg::*;
#(
  parameter int MAX_SIZE = MAX_SIZE_DEF
) (
  input  logic [COORD_W-1:0]          x,
  input  logic [COORD_W-1:0]          y,
  input  logic [MAX_SIZE*COORD_W-1:0] body_x,
  input  logic [MAX_SIZE*COORD_W-1:0] body_y,
  input  logic [SIZE_W-1:0]           len,
  output logic                        hit
);

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < MAX_SIZE; k++) begin
      if ((SIZE_W'(k) < len) &&
          (body_x[k*COORD_W +: COORD_W] == x) &&
          (body_y[k*COORD_W +: COORD_W] == y))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body controller: per tick, steps the head, checks wall/self/item hits,
// then shifts the segment array and grows on an eaten item.
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int XSIZE     = XSIZE_DEF,
  parameter int YSIZE     = YSIZE_DEF,
  parameter int MAX_SIZE  = MAX_SIZE_DEF,
  parameter int INIT_SIZE = 3
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic                        i_Tick,
  input  logic [1:0]                  i_Dir,
  input  logic [5:0]                  i_Item_x,
  input  logic [5:0]                  i_Item_y,
  input  logic                        i_Item_valid,
  output logic [MAX_SIZE*COORD_W-1:0] o_Body_x,
  output logic [MAX_SIZE*COORD_W-1:0] o_Body_y,
  output logic [SIZE_W-1:0]           o_Body_size,
  output logic                        o_Eat,
  output logic                        o_Game_over,
  output logic                        o_Busy
);

  localparam int BW = MAX_SIZE * COORD_W;
  localparam logic [6:0] XLIM = 7'(XSIZE);
  localparam logic [6:0] YLIM = 7'(YSIZE);

  function automatic logic [BW-1:0] init_body(input logic is_x);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < INIT_SIZE; k++)
      v[k*COORD_W +: COORD_W] = is_x ? COORD_W'(XSIZE/2 - k) : COORD_W'(YSIZE/2);
    return v;
  endfunction

  localparam logic [BW-1:0] INIT_X = init_body(1'b1);
  localparam logic [BW-1:0] INIT_Y = init_body(1'b0);

  // Head step in 7-bit signed space so -1 and XSIZE/YSIZE stay distinguishable.
  function automatic logic signed [6:0] step_coord(input logic [5:0] c,
                                                   input logic signed [1:0] d);
    return $signed({1'b0, c}) + $signed({{5{d[1]}}, d});
  endfunction

  state_t                   state_q, state_d;
  dir_t                     dir_q, dir_sel;
  logic [BW-1:0]            body_x_q, body_y_q;
  logic [SIZE_W-1:0]        size_q;
  logic                     eat_q;
  logic                     item_vld_q;
  logic [5:0]               item_x_q, item_y_q;
  logic signed [1:0]        dx, dy;
  logic signed [6:0]        hd_x_p0, hd_y_p0;
  logic [6:0]               hx_u, hy_u;
  logic                     eat_p1;
  logic                     wall, eat_now, self_hit;
  logic [SIZE_W-1:0]        self_len;

  assign dir_sel = (dir_t'(i_Dir) == reverse_dir(dir_q)) ? dir_q : dir_t'(i_Dir);

  always_comb begin
    dx = 2'sb00;
    dy = 2'sb00;
    case (dir_sel)
      DIR_UP:    dy = 2'sb11;
      DIR_DOWN:  dy = 2'sb01;
      DIR_LEFT:  dx = 2'sb11;
      DIR_RIGHT: dx = 2'sb01;
      default:   ;
    endcase
  end

  assign hx_u = hd_x_p0;
  assign hy_u = hd_y_p0;

  // A negative result sets bit 6; y = 64 also lands there since YSIZE fills 6 bits.
  assign wall = hd_x_p0[6] || (hx_u >= XLIM) || hd_y_p0[6] || (hy_u >= YLIM);
  assign eat_now  = item_vld_q && (hx_u == {1'b0, item_x_q}) && (hy_u == {1'b0, item_y_q});
  assign self_len = eat_now ? size_q : size_q - 12'd1;

  snake_hit_detect #(
    .MAX_SIZE (MAX_SIZE)
  ) u_self_hit (
    .x      (hx_u[5:0]),
    .y      (hy_u[5:0]),
    .body_x (body_x_q),
    .body_y (body_y_q),
    .len    (self_len),
    .hit    (self_hit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_Tick) state_d = S_CHECK;
      S_CHECK: state_d = (wall || self_hit) ? S_OVER : S_SHIFT;
      S_SHIFT: state_d = S_IDLE;
      S_OVER:  state_d = S_OVER;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage p0: next head registered on the accepted tick.
  always_ff @(posedge i_Clk) begin
    if (state_q == S_IDLE && i_Tick) begin
      hd_x_p0 <= step_coord(body_x_q[COORD_W-1:0], dx);
      hd_y_p0 <= step_coord(body_y_q[COORD_W-1:0], dy);
    end
    if (i_Item_valid) begin
      item_x_q <= i_Item_x;
      item_y_q <= i_Item_y;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q    <= S_IDLE;
      dir_q      <= DIR_RIGHT;
      body_x_q   <= INIT_X;
      body_y_q   <= INIT_Y;
      size_q     <= SIZE_W'(INIT_SIZE);
      eat_q      <= 1'b0;
      eat_p1     <= 1'b0;
      item_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      eat_q   <= 1'b0;
      if (i_Item_valid)
        item_vld_q <= 1'b1;
      else if (eat_q)
        item_vld_q <= 1'b0;
      case (state_q)
        S_IDLE:  if (i_Tick) dir_q <= dir_sel;
        // Stage p1: eat decision carried into the shift.
        S_CHECK: eat_p1 <= eat_now;
        S_SHIFT: begin
          body_x_q <= {body_x_q[BW-COORD_W-1:0], hx_u[5:0]};
          body_y_q <= {body_y_q[BW-COORD_W-1:0], hy_u[5:0]};
          if (eat_p1 && size_q < SIZE_W'(MAX_SIZE))
            size_q <= size_q + 12'd1;
          eat_q <= eat_p1;
        end
        default: ;
      endcase
    end
  end

  assign o_Body_x    = body_x_q;
  assign o_Body_y    = body_y_q;
  assign o_Body_size = size_q;
  assign o_Eat       = eat_q;
  assign o_Game_over = (state_q == S_OVER);
  assign o_Busy      = (state_q == S_CHECK) || (state_q == S_SHIFT);

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed bench for snake_body_ctrl: movement, eating, reverse rejection,
// wall and self hits, and reset during a shift.
module tb_snake_body_ctrl;

  localparam int MS = 100;

  logic            i_Clk = 1'b0;
  logic            i_Rst = 1'b1;
  logic            i_Tick = 1'b0;
  logic [1:0]      i_Dir = 2'd3;
  logic [5:0]      i_Item_x = '0;
  logic [5:0]      i_Item_y = '0;
  logic            i_Item_valid = 1'b0;
  logic [MS*6-1:0] o_Body_x, o_Body_y;
  logic [11:0]     o_Body_size;
  logic            o_Eat, o_Game_over, o_Busy;

  int n_vec = 0;
  int n_bad = 0;
  int eat_cnt = 0;
  int eat0;

  snake_body_ctrl dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_Tick       (i_Tick),
    .i_Dir        (i_Dir),
    .i_Item_x     (i_Item_x),
    .i_Item_y     (i_Item_y),
    .i_Item_valid (i_Item_valid),
    .o_Body_x     (o_Body_x),
    .o_Body_y     (o_Body_y),
    .o_Body_size  (o_Body_size),
    .o_Eat        (o_Eat),
    .o_Game_over  (o_Game_over),
    .o_Busy       (o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) if (o_Eat === 1'b1) eat_cnt <= eat_cnt + 1;

  function automatic logic [31:0] sx(input int k);
    return {26'd0, o_Body_x[k*6 +: 6]};
  endfunction

  function automatic logic [31:0] sy(input int k);
    return {26'd0, o_Body_y[k*6 +: 6]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_seg(input string tag, input int k, input int x, input int y);
    chk({tag, ".x"}, sx(k), x);
    chk({tag, ".y"}, sy(k), y);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic do_tick(input logic [1:0] d);
    i_Dir  = d;
    i_Tick = 1'b1;
    @(posedge i_Clk);
    #1;
    i_Tick = 1'b0;
    cyc(3);
  endtask

  task automatic load_item(input logic [5:0] x, input logic [5:0] y);
    i_Item_x     = x;
    i_Item_y     = y;
    i_Item_valid = 1'b1;
    cyc(1);
    i_Item_valid = 1'b0;
  endtask

  task automatic reset_dut();
    i_Rst = 1'b0;
    cyc(2);
    i_Rst = 1'b1;
    cyc(1);
  endtask

  initial begin
    // Reset values, observed while reset is held
    #2 i_Rst = 1'b0;
    cyc(2);
    chk("rst_size", o_Body_size, 3);
    chk_seg("rst_seg0", 0, 24, 32);
    chk_seg("rst_seg1", 1, 23, 32);
    chk_seg("rst_seg2", 2, 22, 32);
    chk_seg("rst_seg3", 3, 0, 0);
    chk("rst_eat", o_Eat, 0);
    chk("rst_over", o_Game_over, 0);
    chk("rst_busy", o_Busy, 0);
    i_Rst = 1'b1;
    cyc(1);

    // Straight moves with no item
    eat0 = eat_cnt;
    for (int i = 0; i < 3; i++) begin
      do_tick(2'd3);
      chk_seg("move_head", 0, 25 + i, 32);
    end
    chk_seg("move_tail", 2, 25, 32);
    chk("move_size", o_Body_size, 3);
    chk("move_noeat", eat_cnt - eat0, 0);

    // Eat an item directly ahead
    reset_dut();
    load_item(6'd25, 6'd32);
    eat0 = eat_cnt;
    do_tick(2'd3);
    chk("eat_pulses", eat_cnt - eat0, 1);
    chk("eat_size", o_Body_size, 4);
    chk_seg("eat_seg0", 0, 25, 32);
    chk_seg("eat_seg1", 1, 24, 32);
    chk_seg("eat_seg2", 2, 23, 32);
    chk_seg("eat_seg3", 3, 22, 32);
    chk("eat_latch_clr", dut.item_vld_q, 0);

    // Reverse request ignored, then a legal turn
    reset_dut();
    do_tick(2'd2);
    chk_seg("rev_head", 0, 25, 32);
    do_tick(2'd1);
    chk_seg("turn_head", 0, 25, 33);

    // Wall hit on the right edge
    reset_dut();
    for (int i = 0; i < 23; i++) do_tick(2'd3);
    chk_seg("edge_head", 0, 47, 32);
    chk("edge_over", o_Game_over, 0);
    do_tick(2'd3);
    chk("wall_over", o_Game_over, 1);
    chk("wall_busy", o_Busy, 0);
    chk_seg("wall_head", 0, 47, 32);
    chk("wall_size", o_Body_size, 3);
    do_tick(2'd1);
    chk_seg("over_frozen", 0, 47, 32);
    chk("over_sticky", o_Game_over, 1);

    // Coil into the tail cell: legal without eating, fatal while eating
    reset_dut();
    load_item(6'd25, 6'd32);
    do_tick(2'd3);
    do_tick(2'd1);
    do_tick(2'd2);
    do_tick(2'd0);
    chk("coil_over", o_Game_over, 0);
    chk_seg("coil_head", 0, 24, 32);
    chk_seg("coil_tail", 3, 25, 32);
    chk("coil_size", o_Body_size, 4);
    load_item(6'd25, 6'd32);
    eat0 = eat_cnt;
    do_tick(2'd3);
    chk("coil_eat_over", o_Game_over, 1);
    chk_seg("coil_eat_head", 0, 24, 32);
    chk("coil_eat_size", o_Body_size, 4);
    chk("coil_eat_noeat", eat_cnt - eat0, 0);

    // Asynchronous reset while in SHIFT
    reset_dut();
    i_Dir  = 2'd3;
    i_Tick = 1'b1;
    cyc(1);
    i_Tick = 1'b0;
    chk("shift_busy_chk", o_Busy, 1);
    cyc(1);
    chk("shift_busy_sh", o_Busy, 1);
    i_Rst = 1'b0;
    #1;
    chk("arst_busy", o_Busy, 0);
    chk_seg("arst_head", 0, 24, 32);
    chk("arst_size", o_Body_size, 3);
    chk("arst_over", o_Game_over, 0);
    cyc(1);
    i_Rst = 1'b1;
    cyc(1);
    do_tick(2'd3);
    chk_seg("arst_next", 0, 25, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
